// File: rtl/ntt_core_cut_sequencer.sv
// Two-column radix-cut sequencer for the NTT core: issues per-column beat streams and waits for drain.
// Optional perf counters are built when NTT_CORE_CUT_SEQ_PERF_EN is defined.
module ntt_core_cut_sequencer #(
  parameter int RDX_S0   = 5,
  parameter int RDX_S1   = 6,
  parameter int PSI_LOG  = 3,
  parameter int POLY_MAX = 8,
  localparam int BEAT_NB = 1 << (RDX_S0 + RDX_S1 - 1 - PSI_LOG),
  localparam int POLY_W  = $clog2(POLY_MAX + 1),
  localparam int BEAT_W  = $clog2(BEAT_NB)
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic              cmd_dir,
  input  logic [POLY_W-1:0] cmd_poly_nb,
  output logic              seq_vld,
  input  logic              seq_rdy,
  output logic              seq_col,
  output logic [2:0]        seq_rdx_log,
  output logic              seq_ngc,
  output logic [POLY_W-1:0] seq_poly,
  output logic [BEAT_W-1:0] seq_beat,
  output logic              seq_col_last,
  output logic              seq_last,
  input  logic              col_done,
  output logic              batch_done,
  output logic              busy,
  output logic              err,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_drain_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_NB - 1);
  localparam logic [POLY_W-1:0] POLY_ONE  = POLY_W'(1);

  state_t            state, state_nxt;
  logic [POLY_W-1:0] poly_nb_q;
  logic [POLY_W-1:0] poly_q;
  logic [BEAT_W-1:0] beat_q;
  logic              col_q;
  logic              second_q;
  logic              err_q;
  logic [POLY_W-1:0] poly_last;
  logic              col_last_w;

  assign poly_last  = poly_nb_q - POLY_ONE;
  assign col_last_w = (beat_q == BEAT_LAST) && (poly_q == poly_last);

  always_ff @(posedge clk) begin
    if (s_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_vld) state_nxt = (cmd_poly_nb == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (seq_rdy && col_last_w) state_nxt = S_DRAIN;
      S_DRAIN: if (col_done) state_nxt = second_q ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Beat counters run poly-inner / beat-outer; the wrap on the column's last beat is harmless since DRAIN clears them.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      poly_nb_q <= '0;
      poly_q    <= '0;
      beat_q    <= '0;
      col_q     <= 1'b0;
      second_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (col_done && (state != S_DRAIN)) err_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_vld) begin
            poly_nb_q <= cmd_poly_nb;
            col_q     <= cmd_dir;
            second_q  <= 1'b0;
            poly_q    <= '0;
            beat_q    <= '0;
          end
        end
        S_ISSUE: begin
          if (seq_rdy) begin
            if (poly_q == poly_last) begin
              poly_q <= '0;
              beat_q <= beat_q + 1'b1;
            end else begin
              poly_q <= poly_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (col_done && !second_q) begin
            col_q    <= ~col_q;
            second_q <= 1'b1;
            poly_q   <= '0;
            beat_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Column-derived fields are only meaningful while a beat is presented, so they read zero otherwise.
  always_comb begin
    cmd_rdy      = (state == S_IDLE);
    seq_vld      = (state == S_ISSUE);
    busy         = (state != S_IDLE);
    batch_done   = (state == S_DONE);
    err          = err_q;
    seq_col      = col_q;
    seq_poly     = poly_q;
    seq_beat     = beat_q;
    seq_rdx_log  = '0;
    seq_ngc      = 1'b0;
    seq_col_last = 1'b0;
    seq_last     = 1'b0;
    if (state == S_ISSUE) begin
      seq_rdx_log  = col_q ? 3'(RDX_S1) : 3'(RDX_S0);
      seq_ngc      = ~col_q;
      seq_col_last = col_last_w;
      seq_last     = col_last_w && second_q;
    end
  end

`ifdef NTT_CORE_CUT_SEQ_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] drain_q;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      stall_q <= '0;
      drain_q <= '0;
    end else if ((state == S_IDLE) && cmd_vld) begin
      stall_q <= '0;
      drain_q <= '0;
    end else begin
      if ((state == S_ISSUE) && !seq_rdy && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if ((state == S_DRAIN) && (drain_q != '1)) drain_q <= drain_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_drain_cnt = drain_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_drain_cnt = '0;
`endif

endmodule

// File: doc/ntt_core_cut_sequencer.md
Name: ntt_core_cut_sequencer

Overview:
- Sequences the two radix-cut columns of the NTT core (col 0: negacyclic, log radix 5; col 1: cyclic, log radix 6; N = 2^11).
- Accepts one batch command at a time and streams per-column coefficient-group beats to the column datapath.
- After the last beat of each column, waits for the datapath's col_done (pipeline drain / transpose) before issuing the next column, then signals batch completion.
- Sits between the NTT core front-end command FIFO and the butterfly column datapaths.

Parameters:
- RDX_S0, 5, log2 radix of column 0 (negacyclic), range 1..5
- RDX_S1, 6, log2 radix of column 1 (cyclic), range 1..6
- PSI_LOG, 3, log2 butterflies per cycle; BEAT_NB = 2^(RDX_S0+RDX_S1-1-PSI_LOG) = 128
- POLY_MAX, 8, max polynomials per batch; POLY_W = $clog2(POLY_MAX+1)

Ports:
- clk, in, 1, clock
- s_rst, in, 1, synchronous active-high reset
- cmd_vld, in, 1, batch command valid
- cmd_rdy, out, 1, command accepted when vld&rdy
- cmd_dir, in, 1, 0 = forward (col0 then col1), 1 = backward (col1 then col0)
- cmd_poly_nb, in, POLY_W, polynomials in batch (0..POLY_MAX)
- seq_vld, out, 1, beat valid
- seq_rdy, in, 1, datapath ready
- seq_col, out, 1, current column index
- seq_rdx_log, out, 3, log radix of current column (RDX_S0 or RDX_S1)
- seq_ngc, out, 1, 1 when seq_col==0
- seq_poly, out, POLY_W, polynomial index of beat
- seq_beat, out, $clog2(BEAT_NB), group index of beat
- seq_col_last, out, 1, last beat of current column
- seq_last, out, 1, last beat of batch
- col_done, in, 1, one-cycle pulse: datapath drained current column
- batch_done, out, 1, one-cycle pulse: batch complete
- busy, out, 1, FSM not IDLE
- err, out, 1, sticky protocol error
- perf_stall_cnt, out, 32, see Optional Feature
- perf_drain_cnt, out, 32, see Optional Feature

Behaviour:
- Reset: FSM=IDLE; cmd_rdy=1; seq_vld, batch_done, busy, err = 0; all counters and seq_* fields = 0. Reset mid-batch aborts immediately; no batch_done is emitted.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - cmd_rdy=1.
  - On accept with poly_nb>0: latch dir and poly_nb, col = dir ? 1 : 0, counters = 0, go to ISSUE (first seq_vld on the next cycle).
  - On accept with poly_nb==0: go to DONE, no beats.
- ISSUE:
  - seq_vld=1.
  - Order: beat outer, poly inner (b0p0, b0p1, ..., b0pP-1, b1p0, ...).
  - Counters advance only on seq_vld&seq_rdy; seq_* fields hold stable while stalled.
  - seq_col_last = (beat==BEAT_NB-1)&&(poly==poly_nb-1).
  - seq_last = seq_col_last && second column of the batch.
  - Handshake of the seq_col_last beat goes to DRAIN; seq_vld=0 the next cycle.
- DRAIN:
  - seq_vld=0.
  - On col_done: if the first column, switch col (0<->1), clear counters, go to ISSUE. Otherwise go to DONE.
- DONE: batch_done=1 for one cycle, then IDLE. cmd_rdy=0 in DONE, so the earliest next accept is the cycle after DONE.
- cmd_rdy=0 in ISSUE, DRAIN and DONE. busy=1 in ISSUE, DRAIN and DONE.
- col_done outside DRAIN: ignored and sets err. err clears only on reset.
- Column schedule: exactly 2 columns per batch regardless of dir. seq_rdx_log/seq_ngc derive from col, not from issue order.

Optional Feature:
- Macro NTT_CORE_CUT_SEQ_PERF_EN.
- Defined:
  - perf_stall_cnt counts cycles with seq_vld&!seq_rdy.
  - perf_drain_cnt counts cycles in DRAIN.
  - Both clear on command accept and saturate at 2^32-1.
- Undefined: both outputs tied to 0; no counter registers.

Test Plan:
- Forward, poly_nb=2, seq_rdy=1, col_done 4 cycles after each last beat; accept at T:
  - col0 beats on T+1..T+256 (first b0p0, seq_ngc=1, seq_rdx_log=5).
  - col1 beats on T+261..T+516 (seq_rdx_log=6; seq_last at T+516 with beat=127, poly=1).
  - batch_done at T+521; cmd_rdy=1 at T+522.
- Backward, poly_nb=1: first beat col=1, seq_ngc=0; second column col=0; 128 beats each; seq_last only on final col0 beat.
- Random seq_rdy (50%) with poly_nb=3: fields stable during stalls; 384 beats per column in order; with PERF_EN, perf_stall_cnt equals the number of stall cycles counted by the bench.
- poly_nb=0 accepted at T: no seq_vld; batch_done at T+1; cmd_rdy=1 at T+2.
- col_done pulsed during ISSUE: err=1 and stays high; beat stream unaffected; batch completes normally.
- s_rst asserted at beat 50 of col0: next cycle seq_vld=0, busy=0, cmd_rdy=1, no batch_done; a new batch then runs correctly from b0p0.
